// File: rtl/fetch_mem_arbiter.sv
// rtl/fetch_mem_arbiter.sv - shares one memory port between instruction fetch and load/store.
// Optional macro FETCH_STARVE_GUARD_EN bounds how long data traffic can starve fetch.
module fetch_mem_arbiter #(
  parameter int ADDR_WIDTH   = 30,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  data_req,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  input  logic                  mem_ready,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  fetch_done,
  output logic                  data_done,
  output logic                  block_fetch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   grant_point;
  logic   take_data;

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  // A new grant is taken from IDLE or at the edge that completes the current access.
  assign grant_point = (state == IDLE) || mem_ready;
  assign mem_valid   = (state != IDLE);
  assign fetch_done  = (state == FETCH) && mem_ready;
  assign data_done   = (state == DATA) && mem_ready;
  assign block_fetch = !fetch_done;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;

  // Decision uses the count including a completion happening at this same edge,
  // so exactly STARVE_LIMIT data accesses run before fetch is forced in.
  always_comb begin
    starve_next = starve_cnt;
    if (fetch_done) begin
      starve_next = '0;
    end else if (data_done) begin
      if (!fetch_req) begin
        starve_next = '0;
      end else if (starve_cnt != LIMIT) begin
        starve_next = starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_next;
    end
  end

  assign take_data = data_req && !(fetch_req && (starve_next == LIMIT));
`else
  assign take_data = data_req;
`endif

  always_comb begin
    next_state = state;
    if (grant_point) begin
      if (take_data) begin
        next_state = DATA;
      end else if (fetch_req) begin
        next_state = FETCH;
      end else begin
        next_state = IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Port fields only load at grant points, so they stay stable through wait states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_point) begin
      if (take_data) begin
        mem_write <= data_write;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
      end else if (fetch_req) begin
        mem_write <= 1'b0;
        mem_addr  <= fetch_addr;
      end else begin
        mem_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb/tb_fetch_mem_arbiter.sv - self-checking bench for fetch_mem_arbiter.
module tb_fetch_mem_arbiter;

  localparam int AW    = 30;
  localparam int LIMIT = 4;
`ifdef FETCH_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          data_req;
  logic          data_write;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata;
  logic          mem_ready;
  logic          mem_valid;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          fetch_done;
  logic          data_done;
  logic          block_fetch;

  always #5 clock = ~clock;

  fetch_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .data_req    (data_req),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .mem_ready   (mem_ready),
    .mem_valid   (mem_valid),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .fetch_done  (fetch_done),
    .data_done   (data_done),
    .block_fetch (block_fetch)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_fd  = 0;
  int n_dd  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the access currently owning the port, plus how many data
  // services in a row fetch has sat through while requesting.
  typedef struct {
    bit            busy;
    bit            is_data;
    bit            write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } access_t;

  access_t cur;
  int      waited;

  function automatic void model_reset();
    cur.busy = 1'b0;
    waited   = 0;
  endfunction

  function automatic void model_edge();
    access_t nxt;
    if (cur.busy && !mem_ready) return;
    if (cur.busy) begin
      if (cur.is_data && fetch_req) waited = (waited < LIMIT) ? waited + 1 : LIMIT;
      else waited = 0;
    end
    nxt = '{busy: 1'b0, is_data: 1'b0, write: 1'b0, addr: cur.addr, wdata: cur.wdata};
    if (data_req && !(GUARD && fetch_req && waited == LIMIT)) begin
      nxt = '{busy: 1'b1, is_data: 1'b1, write: data_write, addr: data_addr, wdata: data_wdata};
    end else if (fetch_req) begin
      nxt = '{busy: 1'b1, is_data: 1'b0, write: 1'b0, addr: fetch_addr, wdata: cur.wdata};
    end
    cur = nxt;
  endfunction

  task automatic model_check();
    logic fd_exp;
    fd_exp = cur.busy && !cur.is_data && mem_ready;
    chk("mem_valid", 64'(mem_valid), 64'(cur.busy));
    chk("fetch_done", 64'(fetch_done), 64'(fd_exp));
    chk("data_done", 64'(data_done), 64'(cur.busy && cur.is_data && mem_ready));
    chk("block_fetch", 64'(block_fetch), 64'(!fd_exp));
    if (cur.busy) begin
      chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
      chk("mem_write", 64'(mem_write), 64'(cur.write));
      if (cur.write) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
    end
  endtask

  // Entered at a falling edge with inputs already driven.
  task automatic step();
    #1;
    model_check();
    if (fetch_done) n_fd++;
    if (data_done) n_dd++;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit            fr;
    logic [AW-1:0] fa;
    bit            dr;
    bit            dw;
    logic [AW-1:0] da;
    logic [31:0]   dwd;
    bit            rdy;
    bit            e_valid;
    logic [AW-1:0] e_addr;
    bit            e_write;
    logic [31:0]   e_wdata;
    bit            e_fd;
    bit            e_dd;
    bit            e_block;
  } vec_t;

  vec_t tv[11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1, 'h100, 0, 0, 'h00, 32'h0,        1, 0, 'h000, 0, 32'h0,        0, 0, 1};
    tv[1]  = '{1, 'h100, 1, 1, 'h40, 32'hDEADBEEF, 1, 1, 'h100, 0, 32'h0,        1, 0, 0};
    tv[2]  = '{1, 'h100, 0, 0, 'h00, 32'h0,        1, 1, 'h040, 1, 32'hDEADBEEF, 0, 1, 1};
    tv[3]  = '{1, 'h104, 0, 0, 'h00, 32'h0,        1, 1, 'h100, 0, 32'h0,        1, 0, 0};
    tv[4]  = '{1, 'h104, 1, 0, 'h80, 32'h0,        0, 1, 'h104, 0, 32'h0,        0, 0, 1};
    tv[5]  = '{1, 'h10C, 1, 1, 'hC0, 32'h5555AAAA, 0, 1, 'h104, 0, 32'h0,        0, 0, 1};
    tv[6]  = '{1, 'h104, 1, 0, 'h80, 32'h0,        0, 1, 'h104, 0, 32'h0,        0, 0, 1};
    tv[7]  = '{1, 'h108, 1, 0, 'h80, 32'h0,        1, 1, 'h104, 0, 32'h0,        1, 0, 0};
    tv[8]  = '{0, 'h000, 0, 0, 'h00, 32'h0,        1, 1, 'h080, 0, 32'h0,        0, 1, 1};
    tv[9]  = '{0, 'h000, 0, 0, 'h00, 32'h0,        1, 0, 'h000, 0, 32'h0,        0, 0, 1};
    tv[10] = '{0, 'h000, 0, 0, 'h00, 32'h0,        0, 0, 'h000, 0, 32'h0,        0, 0, 1};

    reset      = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 'h100;
    data_req   = 1'b0;
    data_write = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    mem_ready  = 1'b1;
    model_reset();

    // Reset with a fetch pending, then continuous fetch streaming.
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst mem_valid", 64'(mem_valid), 64'(0));
    chk("rst block_fetch", 64'(block_fetch), 64'(1));
    chk("rst fetch_done", 64'(fetch_done), 64'(0));
    chk("rst mem_addr", 64'(mem_addr), 64'(0));
    chk("rst mem_write", 64'(mem_write), 64'(0));
    chk("rst mem_wdata", 64'(mem_wdata), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    step();
    n_fd = 0;
    for (int i = 0; i < 5; i++) step();
    chk("stream fetch count", 64'(n_fd), 64'(5));

    // Directed table: store interleave, fetch wait states, then idle.
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      fetch_req  = tv[i].fr;
      fetch_addr = tv[i].fa;
      data_req   = tv[i].dr;
      data_write = tv[i].dw;
      data_addr  = tv[i].da;
      data_wdata = tv[i].dwd;
      mem_ready  = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d mem_valid", i), 64'(mem_valid), 64'(tv[i].e_valid));
      chk($sformatf("tv%0d fetch_done", i), 64'(fetch_done), 64'(tv[i].e_fd));
      chk($sformatf("tv%0d data_done", i), 64'(data_done), 64'(tv[i].e_dd));
      chk($sformatf("tv%0d block_fetch", i), 64'(block_fetch), 64'(tv[i].e_block));
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d mem_addr", i), 64'(mem_addr), 64'(tv[i].e_addr));
        chk($sformatf("tv%0d mem_write", i), 64'(mem_write), 64'(tv[i].e_write));
        if (tv[i].e_write) chk($sformatf("tv%0d mem_wdata", i), 64'(mem_wdata), 64'(tv[i].e_wdata));
      end
      @(posedge clock);
      model_edge();
      @(negedge clock);
    end

    // Reset lands in the middle of a stalled store.
    fetch_req  = 1'b0;
    data_req   = 1'b1;
    data_write = 1'b1;
    data_addr  = 'h3C;
    data_wdata = 32'h12345678;
    mem_ready  = 1'b0;
    apply_reset();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst mem_valid", 64'(mem_valid), 64'(0));
    chk("midrst data_done", 64'(data_done), 64'(0));
    chk("midrst block_fetch", 64'(block_fetch), 64'(1));
    mem_ready = 1'b1;
    #1;
    chk("midrst data_done rdy", 64'(data_done), 64'(0));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    n_dd = 0;
    step();
    chk("regrant idle cycle", 64'(n_dd), 64'(0));
    step();
    chk("regrant data_done", 64'(n_dd), 64'(1));

    // Both requesters hammering the port.
    fetch_req  = 1'b1;
    fetch_addr = 'h200;
    data_req   = 1'b1;
    data_write = 1'b0;
    data_addr  = 'h300;
    mem_ready  = 1'b1;
    apply_reset();
    step();
    n_fd = 0;
    n_dd = 0;
    for (int i = 0; i < 20; i++) step();
    chk("contend fetch count", 64'(n_fd), GUARD ? 64'(4) : 64'(0));
    chk("contend data count", 64'(n_dd), GUARD ? 64'(16) : 64'(20));

    // Nobody asking.
    fetch_req = 1'b0;
    data_req  = 1'b0;
    apply_reset();
    n_fd = 0;
    n_dd = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("idle fetch_done", 64'(n_fd), 64'(0));
    chk("idle data_done", 64'(n_dd), 64'(0));
    chk("idle mem_valid", 64'(mem_valid), 64'(0));

    // Randomized traffic against the reference.
    for (int i = 0; i < 500; i++) begin
      fetch_req  = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 2) == 0);
      data_write = 1'($urandom_range(0, 1));
      fetch_addr = AW'($urandom);
      data_addr  = AW'($urandom);
      data_wdata = $urandom;
      mem_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
